// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares a single ALU between two requesters. One transaction is in flight at
// a time: a requester is granted in IDLE, its operands are latched and held on
// the ALU inputs during EXEC (one cycle, or MUL_LAT cycles for a multiply),
// the ALU result is captured, and the response is held in RESP until the
// consumer takes it. Simultaneous requests are resolved round-robin.
//
// Ports
//   clk_i        in   1   clock, all state updates on the rising edge
//   rst_i        in   1   synchronous active-high reset
//   req_valid_i  in   2   per-requester request valid
//   req_ready_o  out  2   per-requester accept (combinational)
//   req_src1_i   in  64   operand 1, requester n in bits [32n+31:32n]
//   req_src2_i   in  64   operand 2, same packing
//   req_ctr_i    in   6   ALU control code, requester n in bits [3n+2:3n]
//   alu_src1_o   out 32   operand 1 to the shared ALU
//   alu_src2_o   out 32   operand 2 to the shared ALU
//   alu_ctr_o    out  3   control code to the shared ALU
//   alu_data_i   in  32   ALU result
//   alu_zero_i   in   1   ALU zero flag
//   rsp_valid_o  out  1   response valid
//   rsp_ready_i  in   1   response consumer ready
//   rsp_id_o     out  1   requester that owns the response
//   rsp_data_o   out 32   captured ALU result
//   rsp_zero_o   out  1   captured ALU zero flag
//   busy_o       out  1   high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [63:0] req_src1_i,
    input  logic [63:0] req_src2_i,
    input  logic [5:0]  req_ctr_i,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [2:0]  alu_ctr_o,
    input  logic [31:0] alu_data_i,
    input  logic        alu_zero_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_zero_o,
    output logic        busy_o
);

    localparam logic [2:0] CTR_MUL = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [3:0]  r_cnt;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [2:0]  r_ctr;
    logic        r_id;
    logic        r_lastGrant;
    logic [31:0] r_rspData;
    logic        r_rspZero;

    logic        w_grantId;
    logic        w_accept;
    logic [31:0] w_selSrc1;
    logic [31:0] w_selSrc2;
    logic [2:0]  w_selCtr;

    // Pick the requester that would be served this cycle. A lone requester
    // always wins; when both ask, the one not granted last time wins.
    always_comb begin
        w_grantId = 1'b0;
        case (req_valid_i)
            2'b01:   w_grantId = 1'b0;
            2'b10:   w_grantId = 1'b1;
            2'b11:   w_grantId = ~r_lastGrant;
            default: w_grantId = 1'b0;
        endcase
    end

    // A transfer happens only in IDLE, outside reset, while the granted
    // requester is still presenting its request.
    assign w_accept  = (r_state == IDLE) && !rst_i && req_valid_i[w_grantId];

    assign w_selSrc1 = w_grantId ? req_src1_i[63:32] : req_src1_i[31:0];
    assign w_selSrc2 = w_grantId ? req_src2_i[63:32] : req_src2_i[31:0];
    assign w_selCtr  = w_grantId ? req_ctr_i[5:3]    : req_ctr_i[2:0];

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. RESP always returns to IDLE first, so a new grant
    // can never be issued in the same cycle a response is consumed.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept)          w_nextState = EXEC;
            EXEC:    if (r_cnt == 4'd0)     w_nextState = RESP;
            RESP:    if (rsp_ready_i)       w_nextState = IDLE;
            default:                        w_nextState = IDLE;
        endcase
    end

    // Datapath registers: latch the granted request, count down the
    // multiply latency, and capture the ALU result on the last EXEC cycle.
    // The lastGrant reset value of 1 makes requester 0 win the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt       <= 4'd0;
            r_src1      <= 32'd0;
            r_src2      <= 32'd0;
            r_ctr       <= 3'd0;
            r_id        <= 1'b0;
            r_lastGrant <= 1'b1;
            r_rspData   <= 32'd0;
            r_rspZero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_src1      <= w_selSrc1;
                r_src2      <= w_selSrc2;
                r_ctr       <= w_selCtr;
                r_id        <= w_grantId;
                r_lastGrant <= w_grantId;
                r_cnt       <= (w_selCtr == CTR_MUL) ? 4'(MUL_LAT - 1) : 4'd0;
            end
            if (r_state == EXEC) begin
                if (r_cnt == 4'd0) begin
                    r_rspData <= alu_data_i;
                    r_rspZero <= alu_zero_i;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    // Output logic. Only the granted requester can see ready, and only in
    // IDLE outside reset.
    always_comb begin
        req_ready_o = 2'b00;
        if ((r_state == IDLE) && !rst_i) begin
            req_ready_o[w_grantId] = req_valid_i[w_grantId];
        end
        rsp_valid_o = (r_state == RESP);
        busy_o      = (r_state != IDLE);
    end

    // The ALU only ever sees the latched operands, so its inputs stay
    // stable for the whole EXEC phase regardless of requester activity.
    assign alu_src1_o = r_src1;
    assign alu_src2_o = r_src2;
    assign alu_ctr_o  = r_ctr;
    assign rsp_id_o   = r_id;
    assign rsp_data_o = r_rspData;
    assign rsp_zero_o = r_rspZero;

endmodule
